// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// fwd_hazard_ctrl : operand-forwarding selects and load-use stall control
// Rev 1.0
// ============================================================================
module fwd_hazard_ctrl #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hold,
   input  logic             flush,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_regwrite,
   input  logic             id_memread,
   output logic             stall,
   output logic             bubble,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
   localparam logic [REG_W-1:0] c_r0      = '0;
   localparam logic [1:0]       c_sel_rf  = 2'b00;
   localparam logic [1:0]       c_sel_wb  = 2'b01;
   localparam logic [1:0]       c_sel_mem = 2'b10;

   // EX slot
   logic             r_ex_vld;
   logic [REG_W-1:0] r_ex_rd;
   logic             r_ex_regwrite;
   logic             r_ex_memread;
   // MEM slot: only the write-back identity matters for forwarding. The WB slot
   // is not stored because the register file is write-before-read.
   logic [REG_W-1:0] r_mem_rd;
   logic             r_mem_regwrite;

   logic [1:0]       r_fwd_a_sel;
   logic [1:0]       r_fwd_b_sel;
   logic [CNT_W-1:0] r_stall_cnt;

   logic             w_stall;
   logic             w_bubble;
   logic [1:0]       w_sel_a;
   logic [1:0]       w_sel_b;

   always_comb begin
      w_stall = !hold && !flush && id_valid && r_ex_vld && r_ex_memread &&
                (r_ex_rd != c_r0) &&
                ((id_uses_rs && (id_rs == r_ex_rd)) ||
                 (id_uses_rt && (id_rt == r_ex_rd)));
      w_bubble = !hold && (w_stall || flush);
   end

   // Newest producer wins: the instruction now in EX will sit in MEM next cycle.
   always_comb begin
      w_sel_a = c_sel_rf;
      if (id_uses_rs && (id_rs != c_r0)) begin
         if (r_ex_regwrite && (r_ex_rd == id_rs))
            w_sel_a = c_sel_mem;
         else if (r_mem_regwrite && (r_mem_rd == id_rs))
            w_sel_a = c_sel_wb;
      end
   end

   always_comb begin
      w_sel_b = c_sel_rf;
      if (id_uses_rt && (id_rt != c_r0)) begin
         if (r_ex_regwrite && (r_ex_rd == id_rt))
            w_sel_b = c_sel_mem;
         else if (r_mem_regwrite && (r_mem_rd == id_rt))
            w_sel_b = c_sel_wb;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex_vld       <= 1'b0;
         r_ex_rd        <= '0;
         r_ex_regwrite  <= 1'b0;
         r_ex_memread   <= 1'b0;
         r_mem_rd       <= '0;
         r_mem_regwrite <= 1'b0;
         r_fwd_a_sel    <= c_sel_rf;
         r_fwd_b_sel    <= c_sel_rf;
         r_stall_cnt    <= '0;
      end else if (!hold) begin
         r_mem_rd       <= r_ex_rd;
         r_mem_regwrite <= r_ex_regwrite;
         if (w_bubble) begin
            r_ex_vld      <= 1'b0;
            r_ex_rd       <= '0;
            r_ex_regwrite <= 1'b0;
            r_ex_memread  <= 1'b0;
            r_fwd_a_sel   <= c_sel_rf;
            r_fwd_b_sel   <= c_sel_rf;
         end else begin
            r_ex_vld      <= id_valid;
            r_ex_rd       <= id_rd;
            r_ex_regwrite <= id_regwrite && id_valid;
            r_ex_memread  <= id_memread;
            r_fwd_a_sel   <= w_sel_a;
            r_fwd_b_sel   <= w_sel_b;
         end
         if (w_stall && (r_stall_cnt != c_cnt_max))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign stall     = w_stall;
   assign bubble    = w_bubble;
   assign fwd_a_sel = r_fwd_a_sel;
   assign fwd_b_sel = r_fwd_b_sel;
   assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fwd_hazard_ctrl : directed scenarios plus random traffic vs. pipeline model
// Rev 1.0
// ============================================================================
module tb_fwd_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst, hold, flush;
   logic       id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       stall, bubble, stall2, bubble2;
   logic [1:0] fwd_a_sel, fwd_b_sel, fwd_a2, fwd_b2;
   logic [15:0] stall_cnt;
   logic [1:0]  stall_cnt2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fwd_hazard_ctrl #(.REG_W(5), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
      .stall(stall), .bubble(bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .stall_cnt(stall_cnt)
   );

   fwd_hazard_ctrl #(.REG_W(5), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
      .stall(stall2), .bubble(bubble2), .fwd_a_sel(fwd_a2), .fwd_b_sel(fwd_b2),
      .stall_cnt(stall_cnt2)
   );

   // In-flight instructions, index 0 = EX (youngest), 1 = MEM.
   typedef struct {
      bit     vld;
      int     rd;
      bit     rw;
      bit     mr;
   } instr_t;

   instr_t pipe[2];
   int     m_a, m_b, m_cnt, m_cnt2;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_stall();
      if (hold || flush || !id_valid) return 0;
      if (!(pipe[0].vld && pipe[0].mr && pipe[0].rd != 0)) return 0;
      return (id_uses_rs && int'(id_rs) == pipe[0].rd) ||
             (id_uses_rt && int'(id_rt) == pipe[0].rd);
   endfunction

   function automatic int m_fwd(input int r, input bit used);
      if (!used || r == 0) return 0;
      for (int k = 0; k < 2; k++)
         if (pipe[k].rw && pipe[k].rd == r) return (k == 0) ? 2 : 1;
      return 0;
   endfunction

   // One clock: compare at the falling edge, then advance the model on the rising edge.
   task automatic step();
      bit es, eb;
      @(negedge clk);
      es = m_stall();
      eb = !hold && (es || flush);
      chk("stall", int'(stall), int'(es));
      chk("bubble", int'(bubble), int'(eb));
      chk("fwd_a", int'(fwd_a_sel), m_a);
      chk("fwd_b", int'(fwd_b_sel), m_b);
      chk("cnt16", int'(stall_cnt), m_cnt);
      chk("cnt2", int'(stall_cnt2), m_cnt2);
      @(posedge clk);
      if (rst) begin
         pipe[0] = '{default: 0};
         pipe[1] = '{default: 0};
         m_a = 0; m_b = 0; m_cnt = 0; m_cnt2 = 0;
      end else if (!hold) begin
         if (es) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
         end
         if (eb) begin
            m_a = 0; m_b = 0;
         end else begin
            m_a = m_fwd(int'(id_rs), id_uses_rs);
            m_b = m_fwd(int'(id_rt), id_uses_rt);
         end
         pipe[1] = pipe[0];
         if (eb) pipe[0] = '{default: 0};
         else    pipe[0] = '{vld: id_valid, rd: int'(id_rd),
                             rw: id_regwrite && id_valid, mr: id_memread};
      end
      #1;
   endtask

   task automatic set_id(input bit v, input int rs, input int rt, input bit urs,
                         input bit urt, input int rd, input bit rw, input bit mr);
      id_valid = v;   id_rs = 5'(rs);  id_rt = 5'(rt);
      id_uses_rs = urs; id_uses_rt = urt;
      id_rd = 5'(rd); id_regwrite = rw; id_memread = mr;
   endtask

   task automatic nop();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      pipe[0] = '{default: 0};
      pipe[1] = '{default: 0};
      m_a = 0; m_b = 0; m_cnt = 0; m_cnt2 = 0;
      rst = 1; hold = 0; flush = 0;
      nop();
      #1;
      step(); step();
      rst = 0;
      chk("rst_a", int'(fwd_a_sel), 0);
      chk("rst_cnt", int'(stall_cnt), 0);

      // add r3 -> sub r6, r3, r4
      set_id(1, 1, 2, 1, 1, 3, 1, 0); step();
      set_id(1, 3, 4, 1, 1, 6, 1, 0); step();
      chk("t1_a", int'(fwd_a_sel), 2);
      chk("t1_b", int'(fwd_b_sel), 0);

      // add r3, nop, or with rt = r3
      set_id(1, 1, 2, 1, 1, 3, 1, 0); step();
      nop(); step();
      set_id(1, 8, 3, 1, 1, 9, 1, 0); step();
      chk("t2_b", int'(fwd_b_sel), 1);
      chk("t2_a", int'(fwd_a_sel), 0);

      // lw r5 -> add with rs = r5
      set_id(1, 1, 0, 1, 0, 5, 1, 1); step();
      set_id(1, 5, 2, 1, 1, 10, 1, 0); #1;
      chk("t3_stall", int'(stall), 1);
      chk("t3_bubble", int'(bubble), 1);
      step();
      chk("t3_stall_off", int'(stall), 0);
      step();
      chk("t3_a", int'(fwd_a_sel), 1);
      chk("t3_cnt", int'(stall_cnt), 1);

      // two writers of r7, consumer reads r7 twice; then r0 writer
      set_id(1, 1, 2, 1, 1, 7, 1, 0); step();
      set_id(1, 1, 2, 1, 1, 7, 1, 0); step();
      set_id(1, 7, 7, 1, 1, 11, 1, 0); step();
      chk("t4_a", int'(fwd_a_sel), 2);
      chk("t4_b", int'(fwd_b_sel), 2);
      set_id(1, 1, 2, 1, 1, 0, 1, 0); step();
      set_id(1, 0, 0, 1, 1, 12, 1, 0); step();
      chk("t4_r0_a", int'(fwd_a_sel), 0);
      chk("t4_r0_b", int'(fwd_b_sel), 0);

      // flush beats stall
      set_id(1, 1, 0, 1, 0, 5, 1, 1); step();
      set_id(1, 5, 0, 1, 0, 13, 1, 0); flush = 1; #1;
      chk("t5_fl_stall", int'(stall), 0);
      chk("t5_fl_bubble", int'(bubble), 1);
      step();
      flush = 0;
      chk("t5_fl_cnt", int'(stall_cnt), 1);

      // hold freezes everything, stall fires once hold drops
      set_id(1, 1, 0, 1, 0, 5, 1, 1); step();
      set_id(1, 5, 0, 1, 0, 13, 1, 0); hold = 1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("t5_hold_stall", int'(stall), 0);
         step();
      end
      hold = 0; #1;
      chk("t5_after_hold", int'(stall), 1);
      step(); step();
      chk("t5_cnt", int'(stall_cnt), 2);

      // reset with a load in EX
      set_id(1, 1, 0, 1, 0, 5, 1, 1); step();
      rst = 1; nop(); step();
      rst = 0;
      set_id(1, 5, 5, 1, 1, 14, 1, 0); #1;
      chk("t6_stall", int'(stall), 0);
      chk("t6_a", int'(fwd_a_sel), 0);
      chk("t6_cnt", int'(stall_cnt), 0);
      step();

      // four load-use stalls: the 2-bit counter must saturate
      for (int i = 0; i < 4; i++) begin
         set_id(1, 0, 0, 0, 0, 5, 1, 1); step();
         set_id(1, 5, 0, 1, 0, 15, 1, 0); step(); step();
      end
      chk("t6_sat2", int'(stall_cnt2), 3);
      chk("t6_cnt16", int'(stall_cnt), 4);

      // random traffic on a small register set to provoke hazards
      for (int i = 0; i < 800; i++) begin
         rst   = ($urandom_range(0, 59) == 0);
         hold  = ($urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 9) == 0);
         set_id($urandom_range(0, 4) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);
         step();
      end

      rst = 0; hold = 0; flush = 0; nop();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
